imac: RTL and testbench
=======================

# imac

Inverse Haar reconstruction unit for the 2-D DWT datapath. It accepts one packed coefficient word {L, H} per handshake and computes the two reconstructed 8-bit pixels. It emits them one per cycle on a valid/ready output, with pixel pointers expanded from coefficient index to pixel index. It sits at the head of the inverse path and consumes the coefficient stream the forward lifting stage produces.

## Interface
- HEIGHT, 256, image height in pixels.
- WIDTH, 256, image width in pixels (power of two); PW = $clog2(WIDTH).
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- coef_input  input  16  packed coefficient: [15:8] = L (average), [7:0] = H (difference).
- i_valid  input  1  coefficient word valid.
- o_ready  output  1  unit can accept a coefficient this cycle.
- i_mode  input  1  row/column pass tag, carried with the data.
- i_row_column_pointer  input  PW  row (or column) index of the coefficient.
- i_pixel_pointer  input  PW  coefficient-pair index; only values < WIDTH/2 are legal.
- pixel_output  output  8  reconstructed pixel.
- o_valid  output  1  pixel_output and tags are valid.
- i_ready  input  1  downstream accepts a pixel this cycle.
- o_mode  output  1  tag copied from the accepted coefficient.
- o_row_column_pointer  output  PW  copied from the accepted coefficient.
- o_pixel_pointer  output  PW  pixel index: 2*i_pixel_pointer for the first pixel, 2*i_pixel_pointer+1 for the second.

## Operation
- Accept occurs when i_valid && o_ready. On accept, the unit latches mode, row/column pointer, pixel pointer, A and B.
- A = min(L + H, 255), using a 9-bit sum.
- B = (L < H) ? 0 : L − H.
- All arithmetic is unsigned. The reconstruction is approximate by definition, because the forward stage truncates.
- FSM states:
  - IDLE: o_valid=0, o_ready=1. On accept, go to SEND_A.
  - SEND_A: pixel_output=A, o_pixel_pointer=2p, o_valid=1, o_ready=0. If i_ready, go to SEND_B; otherwise stay.
  - SEND_B: pixel_output=B, o_pixel_pointer=2p+1, o_valid=1, o_ready=i_ready. If i_ready and accept, load the new word and go to SEND_A. If i_ready and no accept, go to IDLE. If !i_ready, stay.
- Stall rule: while o_valid && !i_ready, pixel_output, o_pixel_pointer, o_mode and o_row_column_pointer hold stable.
- o_mode and o_row_column_pointer are identical for both pixels of a pair.
- i_valid with o_ready=0 is ignored. Upstream must hold the word until the accept.
- rst (any time, including mid-pair) forces IDLE. Any pending pixel is discarded.
- Reset values: pixel_output=0, o_valid=0, o_mode=0, o_row_column_pointer=0, o_pixel_pointer=0. o_ready=1 (it is decoded from IDLE).

## Timing
- Accept at edge t → first pixel (A) valid from t+1. Second pixel (B) is valid the cycle after A is taken.
- o_ready is combinational from state and i_ready only. There is no path from i_valid to o_ready.
- Sustained throughput is 1 coefficient per 2 cycles, i.e. 1 pixel per cycle, with no bubble between pairs when i_valid is held and i_ready=1.
- Outputs are registered. The only combinational output is o_ready.

## Structure
- Shared package dwt_pkg holds:
  - PIX_W=8 and COEF_W=16.
  - The state enum {IDLE, SEND_A, SEND_B}.
  - The pointer width function/localparam derived from WIDTH.
- Natural sub-module: haar_inv_core. It is combinational: (L, H) → (A, B) with the saturation rules above, and is instanced once in imac.
- imac holds the FSM, the A/B/tag registers and the pointer expansion.

## Test plan
- Reset, then one word {L=100, H=20}, i_pixel_pointer=5, row 3, i_ready=1 → pixels 120 at pointer 10, then 80 at pointer 11; row 3 on both; o_valid low after.
- {L=250, H=10} → A saturates to 255, B=240. {L=5, H=9} → A=14, B clamps to 0.
- Back-to-back words with i_valid held and i_ready=1 → continuous o_valid. o_ready pulses high only in the SEND_B cycle. Pixel order is A0 B0 A1 B1.
- Downstream stall: i_ready low for 3 cycles during SEND_A and again during SEND_B → outputs held bit-stable. No word is accepted; o_ready=0 throughout the stall.
- Assert rst asynchronously mid-SEND_A → o_valid drops immediately and all outputs go to 0. After release, o_ready=1 and the next word reconstructs correctly.
- Round trip: sweep all (a, b) 8-bit pairs through the forward average/difference with clamp, then through imac → output matches the defined A/B formulas exactly; i_mode tag preserved.

Source files
------------

// File: rtl/dwt_pkg.sv
// Shared definitions for the inverse DWT path: data widths, reconstruction FSM states
// and the pointer width helper.
package dwt_pkg;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } state_e;

    // Bits needed to index one line of an image that is `width` pixels wide.
    function automatic int ptr_w(input int width);
        return (width > 2) ? $clog2(width) : 2;
    endfunction

endpackage

// File: rtl/haar_inv_core.sv
// Combinational inverse Haar step.
// Rebuilds the pixel pair (A, B) from one average/difference coefficient pair (L, H).
module haar_inv_core
    import dwt_pkg::*;
(
    input  logic [PIX_W-1:0] l_i,
    input  logic [PIX_W-1:0] h_i,
    output logic [PIX_W-1:0] a_o,
    output logic [PIX_W-1:0] b_o
);

    logic [PIX_W:0] sum;

    assign sum = {1'b0, l_i} + {1'b0, h_i};

    // The forward stage truncates, so both results clamp into the pixel range.
    assign a_o = sum[PIX_W] ? {PIX_W{1'b1}} : sum[PIX_W-1:0];
    assign b_o = (l_i < h_i) ? '0 : (l_i - h_i);

endmodule

// File: rtl/imac.sv
// Inverse Haar reconstruction unit.
// Takes one {L, H} word per handshake and streams out the two rebuilt pixels.
module imac
    import dwt_pkg::*;
#(
    parameter int   HEIGHT = 256,
    parameter int   WIDTH  = 256,
    localparam int  PW     = ptr_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COEF_W-1:0] coef_input,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_mode,
    input  logic [PW-1:0]     i_row_column_pointer,
    input  logic [PW-1:0]     i_pixel_pointer,
    output logic [PIX_W-1:0]  pixel_output,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_mode,
    output logic [PW-1:0]     o_row_column_pointer,
    output logic [PW-1:0]     o_pixel_pointer
);

    // The row/column pointer shares PW bits between both passes.
    if (HEIGHT > WIDTH) begin : g_height_check
        $error("imac: HEIGHT must not exceed WIDTH");
    end

    state_e           state_q;
    logic [PIX_W-1:0] pix_q;
    logic [PIX_W-1:0] b_q;
    logic             valid_q;
    logic             mode_q;
    logic [PW-1:0]    row_q;
    logic [PW-1:0]    ptr_q;

    logic [PIX_W-1:0] core_a;
    logic [PIX_W-1:0] core_b;
    logic [PW-1:0]    pair_base;
    logic             accept;

    haar_inv_core u_core (
        .l_i (coef_input[COEF_W-1:PIX_W]),
        .h_i (coef_input[PIX_W-1:0]),
        .a_o (core_a),
        .b_o (core_b)
    );

    // Coefficient index p owns pixels 2p and 2p+1; p is always below WIDTH/2.
    assign pair_base = {i_pixel_pointer[PW-2:0], 1'b0};

    assign o_ready = (state_q == IDLE) || ((state_q == SEND_B) && i_ready);
    assign accept  = i_valid && o_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pix_q   <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            row_q   <= '0;
            ptr_q   <= '0;
        end else if (accept) begin
            state_q <= SEND_A;
            pix_q   <= core_a;
            b_q     <= core_b;
            valid_q <= 1'b1;
            mode_q  <= i_mode;
            row_q   <= i_row_column_pointer;
            ptr_q   <= pair_base;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= IDLE;
                end
                SEND_A: begin
                    if (i_ready) begin
                        state_q  <= SEND_B;
                        pix_q    <= b_q;
                        ptr_q[0] <= 1'b1;
                    end
                end
                SEND_B: begin
                    // Reaching here with i_ready set means the pair is done and nothing new came in.
                    if (i_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign pixel_output         = pix_q;
    assign o_valid              = valid_q;
    assign o_mode               = mode_q;
    assign o_row_column_pointer = row_q;
    assign o_pixel_pointer      = ptr_q;

endmodule

// File: tb/tb_imac.sv
// Directed bench for imac: hand-computed pixel pairs, handshake, stall and reset behaviour,
// plus a forward/inverse round trip over a grid of pixel pairs.
module tb_imac;
    import dwt_pkg::*;

    localparam int WIDTH  = 256;
    localparam int HEIGHT = 256;
    localparam int PW     = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [COEF_W-1:0] coef_input;
    logic              i_valid;
    logic              o_ready;
    logic              i_mode;
    logic [PW-1:0]     i_row_column_pointer;
    logic [PW-1:0]     i_pixel_pointer;
    logic [PIX_W-1:0]  pixel_output;
    logic              o_valid;
    logic              i_ready;
    logic              o_mode;
    logic [PW-1:0]     o_row_column_pointer;
    logic [PW-1:0]     o_pixel_pointer;

    imac #(.HEIGHT(HEIGHT), .WIDTH(WIDTH)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .coef_input           (coef_input),
        .i_valid              (i_valid),
        .o_ready              (o_ready),
        .i_mode               (i_mode),
        .i_row_column_pointer (i_row_column_pointer),
        .i_pixel_pointer      (i_pixel_pointer),
        .pixel_output         (pixel_output),
        .o_valid              (o_valid),
        .i_ready              (i_ready),
        .o_mode               (o_mode),
        .o_row_column_pointer (o_row_column_pointer),
        .o_pixel_pointer      (o_pixel_pointer)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_a(input logic [7:0] l, input logic [7:0] h);
        logic [8:0] s;
        s = {1'b0, l} + {1'b0, h};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] model_b(input logic [7:0] l, input logic [7:0] h);
        return (l < h) ? 8'd0 : (l - h);
    endfunction

    typedef struct packed {
        logic [7:0]    pix;
        logic [PW-1:0] ptr;
        logic [PW-1:0] row;
        logic          mode;
    } px_t;

    px_t exp_q[$];

    // Scoreboard: each accepted word queues its two pixels; each transfer pops one.
    always @(negedge clk) begin
        px_t e;
        px_t e2;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_pix",  pixel_output, e.pix);
                    check("mon_ptr",  o_pixel_pointer, e.ptr);
                    check("mon_row",  o_row_column_pointer, e.row);
                    check("mon_mode", o_mode, e.mode);
                end
            end
            if (i_valid && o_ready) begin
                e.pix   = model_a(coef_input[15:8], coef_input[7:0]);
                e.ptr   = {i_pixel_pointer[PW-2:0], 1'b0};
                e.row   = i_row_column_pointer;
                e.mode  = i_mode;
                e2      = e;
                e2.pix  = model_b(coef_input[15:8], coef_input[7:0]);
                e2.ptr  = {i_pixel_pointer[PW-2:0], 1'b1};
                exp_q.push_back(e);
                exp_q.push_back(e2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [7:0] l, input logic [7:0] h, input logic [PW-1:0] p,
                            input logic [PW-1:0] row, input logic mode);
        coef_input           = {l, h};
        i_pixel_pointer      = p;
        i_row_column_pointer = row;
        i_mode               = mode;
    endtask

    // One isolated word with i_ready high: A, then B, then idle.
    task automatic pair(input string name, input logic [7:0] l, input logic [7:0] h,
                        input logic [PW-1:0] p, input logic [PW-1:0] row, input logic mode,
                        input logic [7:0] exp_a, input logic [7:0] exp_b);
        set_word(l, h, p, row, mode);
        i_valid = 1'b1;
        i_ready = 1'b1;
        #1;
        check({name, "_ready_idle"}, o_ready, 1'b1);
        tick();
        i_valid = 1'b0;
        check({name, "_valid_a"}, o_valid, 1'b1);
        check({name, "_pix_a"}, pixel_output, exp_a);
        check({name, "_ptr_a"}, o_pixel_pointer, {p[PW-2:0], 1'b0});
        check({name, "_row_a"}, o_row_column_pointer, row);
        check({name, "_mode_a"}, o_mode, mode);
        check({name, "_ready_a"}, o_ready, 1'b0);
        tick();
        check({name, "_valid_b"}, o_valid, 1'b1);
        check({name, "_pix_b"}, pixel_output, exp_b);
        check({name, "_ptr_b"}, o_pixel_pointer, {p[PW-2:0], 1'b1});
        check({name, "_row_b"}, o_row_column_pointer, row);
        check({name, "_ready_b"}, o_ready, 1'b1);
        tick();
        check({name, "_valid_after"}, o_valid, 1'b0);
        $display("pair %s L=%0d H=%0d -> A=%0d B=%0d", name, l, h, exp_a, exp_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int guard;
        logic acc;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] s;
        logic [7:0] l;
        logic [7:0] h;

        rst = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        set_word(8'd0, 8'd0, '0, '0, 1'b0);
        tick();
        tick();
        check("rst_valid", o_valid, 1'b0);
        check("rst_pix", pixel_output, 8'd0);
        check("rst_ptr", o_pixel_pointer, 8'd0);
        check("rst_row", o_row_column_pointer, 8'd0);
        check("rst_mode", o_mode, 1'b0);
        check("rst_ready", o_ready, 1'b1);
        rst = 1'b0;
        tick();
        $display("reset released");

        pair("basic", 8'd100, 8'd20, 8'd5, 8'd3, 1'b1, 8'd120, 8'd80);
        pair("sat_a", 8'd250, 8'd10, 8'd0, 8'd1, 1'b0, 8'd255, 8'd240);
        pair("clamp_b", 8'd5, 8'd9, 8'd127, 8'd255, 1'b1, 8'd14, 8'd0);

        // Back-to-back words with i_ready held high.
        set_word(8'd60, 8'd10, 8'd0, 8'd7, 1'b1);
        i_valid = 1'b1;
        tick();
        set_word(8'd200, 8'd100, 8'd127, 8'd8, 1'b0);
        check("b2b_a0_pix", pixel_output, 8'd70);
        check("b2b_a0_ready", o_ready, 1'b0);
        tick();
        check("b2b_b0_pix", pixel_output, 8'd50);
        check("b2b_b0_ptr", o_pixel_pointer, 8'd1);
        check("b2b_b0_ready", o_ready, 1'b1);
        tick();
        i_valid = 1'b0;
        check("b2b_a1_valid", o_valid, 1'b1);
        check("b2b_a1_pix", pixel_output, 8'd255);
        check("b2b_a1_ptr", o_pixel_pointer, 8'd254);
        check("b2b_a1_ready", o_ready, 1'b0);
        tick();
        check("b2b_b1_pix", pixel_output, 8'd100);
        check("b2b_b1_ptr", o_pixel_pointer, 8'd255);
        check("b2b_b1_row", o_row_column_pointer, 8'd8);
        tick();
        check("b2b_idle", o_valid, 1'b0);
        $display("back-to-back pairs done");

        // Downstream stall in SEND_A and in SEND_B with a new word waiting.
        set_word(8'd30, 8'd40, 8'd2, 8'd9, 1'b1);
        i_valid = 1'b1;
        tick();
        set_word(8'd1, 8'd2, 8'd3, 8'd10, 1'b0);
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_a_pix", pixel_output, 8'd70);
            check("stall_a_ptr", o_pixel_pointer, 8'd4);
            check("stall_a_row", o_row_column_pointer, 8'd9);
            check("stall_a_mode", o_mode, 1'b1);
            check("stall_a_valid", o_valid, 1'b1);
            check("stall_a_ready", o_ready, 1'b0);
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        #1;
        check("stall_b_ready0", o_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_b_pix", pixel_output, 8'd0);
            check("stall_b_ptr", o_pixel_pointer, 8'd5);
            check("stall_b_row", o_row_column_pointer, 8'd9);
            check("stall_b_valid", o_valid, 1'b1);
            check("stall_b_ready", o_ready, 1'b0);
        end
        i_ready = 1'b1;
        #1;
        check("stall_release_ready", o_ready, 1'b1);
        tick();
        i_valid = 1'b0;
        check("stall_next_pix", pixel_output, 8'd3);
        check("stall_next_ptr", o_pixel_pointer, 8'd6);
        check("stall_next_row", o_row_column_pointer, 8'd10);
        tick();
        check("stall_next_b", pixel_output, 8'd0);
        tick();
        check("stall_idle", o_valid, 1'b0);
        $display("stall sequence done");

        // Asynchronous reset in the middle of SEND_A.
        set_word(8'd10, 8'd10, 8'd1, 8'd4, 1'b1);
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("arst_pre_valid", o_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", o_valid, 1'b0);
        check("arst_pix", pixel_output, 8'd0);
        check("arst_ptr", o_pixel_pointer, 8'd0);
        check("arst_row", o_row_column_pointer, 8'd0);
        check("arst_mode", o_mode, 1'b0);
        check("arst_ready", o_ready, 1'b1);
        #3 rst = 1'b0;
        tick();
        check("arst_after_valid", o_valid, 1'b0);
        $display("async reset done");
        pair("post_rst", 8'd77, 8'd3, 8'd9, 8'd2, 1'b0, 8'd80, 8'd74);

        // Round trip: forward average/difference with clamp, then through the unit.
        k = 0;
        guard = 0;
        while (k < 288 && guard < 5000) begin
            a = 8'((k / 16) * 15);
            b = 8'((k % 16) * 17);
            s = {1'b0, a} + {1'b0, b};
            l = s[8:1];
            h = (a > b) ? (a - b) : 8'd0;
            set_word(l, h, 8'(k % 128), 8'(k % 256), 1'(k ^ (k >> 3)));
            i_valid = 1'b1;
            i_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc = o_ready;
            tick();
            if (acc) k++;
            guard++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("rt_words_sent", k, 288);
        check("rt_queue_drained", exp_q.size(), 0);
        $display("round trip words=%0d", k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
